ahb_arbiter_slave_gen: RTL and testbench
========================================

AHB_ARBITER_SLAVE_GEN -- requirements
Module: ahb_arbiter_slave_gen

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 4: number of requesting masters, legal range 1..16.
REQ-002 SHALL have parameter PRIOR_LEVEL, default 4: number of dynamic priority levels, minimum 2.
REQ-003 SHALL have parameter PRIOR_BIT, default $clog2(PRIOR_LEVEL): width of each priority field.
REQ-004 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority, 1 = dynamic priority, 2 = round robin.
REQ-005 SHALL have parameter STARVE_LIMIT, default 15: wait-cycle threshold for aging; 0 disables aging.
REQ-006 SHALL have port hclk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port hreset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port hreq, input, MASTER_NUM bits: per-master request.
REQ-009 SHALL have port hlast, input, MASTER_NUM bits: per-master last-transfer-of-burst flag.
REQ-010 SHALL have port hprior, input, MASTER_NUM x PRIOR_BIT bits: per-master priority; used only when ARB_MODE = 1.
REQ-011 SHALL have port hwait, input, 1 bit: slave wait state.
REQ-012 SHALL have port hgrant, output, MASTER_NUM bits: one-hot grant, qualified by ~hwait.
REQ-013 SHALL have port hsel, output, 1 bit: slave select; high while any master owns the slave.
REQ-014 SHALL have port hmaster, output, $clog2(MASTER_NUM) bits (min 1): index of the current owner; 0 when idle.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no owner) and OWN (registered one-hot grant, one bit set).
- IDLE -> OWN when any hreq bit is set; the winner is registered.
- OWN -> OWN (new owner) on release when other requests are pending; no idle bubble.
- OWN -> IDLE on release when no requests are pending.
REQ-016 SHALL define release as either of:
- hlast[owner] & ~hwait sampled high;
- hreq[owner] sampled low (abort).
REQ-017 SHALL hold the grant unchanged, whatever the other requests, while hwait is high or while the owner has not released.
REQ-018 SHALL drive combinational outputs as:
- hgrant = grant_reg & {MASTER_NUM{~hwait}};
- hsel = |grant_reg;
- hmaster = encode(grant_reg).
REQ-019 SHALL arbitrate in ARB_MODE 0 so that the lowest-index requester wins.
REQ-020 SHALL arbitrate in ARB_MODE 1 so that the highest hprior value wins; ties go to the lowest index.
REQ-021 SHALL arbitrate in ARB_MODE 2 with a search starting at rr_ptr+1, wrapping modulo MASTER_NUM.
- rr_ptr is loaded with the new owner's index on every grant.
REQ-022 SHALL include the releasing owner as a candidate at re-arbitration, at its normal rank (round robin naturally puts it last).
REQ-023 SHALL keep, when STARVE_LIMIT > 0, a saturating wait counter per master of width $clog2(STARVE_LIMIT+1).
- Increments each cycle the master requests and is not the owner.
- Clears when the master is granted or when its hreq is low.
REQ-024 SHALL give a starved master (counter == STARVE_LIMIT) precedence over all non-starved masters in every mode; among starved masters the lowest index wins.
REQ-025 SHALL produce the arbitration result combinationally and register it, giving exactly 1 cycle latency from request or release to grant_reg.
REQ-026 SHALL, with MASTER_NUM = 1, grant master 0 whenever it requests; the aging and round-robin logic then has no effect.
REQ-027 SHALL never set more than one grant_reg bit; an assertion checks $onehot0(grant_reg) every cycle.

Reset
REQ-028 SHALL, on hreset_n low, asynchronously set:
- grant_reg = 0, FSM = IDLE;
- rr_ptr = MASTER_NUM-1, so master 0 is first in round robin;
- all wait counters = 0.
REQ-029 SHALL, during reset, drive hgrant = 0, hsel = 0 and hmaster = 0; an assertion of reset mid-burst drops ownership immediately.
REQ-030 SHALL, after reset deassertion, arbitrate on the first rising edge at which hreq is nonzero.

Verification
REQ-031 Mode 0, N=4: hreq=4'b1010 with no hlast -> master 1 granted one cycle later and held; hlast[1]=1, hwait=0 -> master 3 granted next cycle with no IDLE cycle.
REQ-032 Mode 1: hprior={1,3,3,0} (masters 3..0), all requesting -> master 1 granted; hwait=1 during hlast[1] -> grant held and hgrant=0 until hwait=0.
REQ-033 Mode 2: all 4 requesting continuously, every transfer hlast=1, hwait=0 -> grant sequence 0,1,2,3,0,...
REQ-034 Mode 0, STARVE_LIMIT=3: masters 0 and 2 requesting continuously, single-beat bursts -> master 2 granted after its counter reaches 3, then the counter clears.
REQ-035 Owner 2 drops hreq with no hlast while master 0 is requesting -> master 0 granted next cycle.
REQ-036 hreset_n pulsed low mid-burst -> hgrant, hsel and hmaster go to 0 immediately; after release with hreq=4'b0001 -> master 0 granted one cycle later.

Source files
------------

// File: rtl/ahb_arbiter_slave_gen_if.sv
// ahb_arbiter_slave_gen_if
// Bundles the request/grant signals between the bus masters and the arbiter
// that owns a single AHB slave.
//   hreq    : per-master request
//   hlast   : per-master last-transfer-of-burst flag
//   hprior  : per-master priority field (PRIOR_BIT bits each, master 0 in the LSBs)
//   hwait   : slave wait state
//   hgrant  : one-hot grant, masked while hwait is high
//   hsel    : slave select, high while any master owns the slave
//   hmaster : index of the current owner, 0 when idle
// Modports:
//   master : the requesting side (drives hreq/hlast/hprior/hwait)
//   slave  : the arbiter side (drives hgrant/hsel/hmaster)
interface ahb_arbiter_slave_gen_if #(
  parameter int MASTER_NUM = 4,
  parameter int PRIOR_BIT  = 2
) ();
  localparam int MW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  logic [MASTER_NUM-1:0]           hreq;
  logic [MASTER_NUM-1:0]           hlast;
  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior;
  logic                            hwait;
  logic [MASTER_NUM-1:0]           hgrant;
  logic                            hsel;
  logic [MW-1:0]                   hmaster;

  modport master (
    output hreq,
    output hlast,
    output hprior,
    output hwait,
    input  hgrant,
    input  hsel,
    input  hmaster
  );

  modport slave (
    input  hreq,
    input  hlast,
    input  hprior,
    input  hwait,
    output hgrant,
    output hsel,
    output hmaster
  );
endinterface

// File: rtl/ahb_arbiter_slave_gen.sv
// ahb_arbiter_slave_gen
// Arbitrates ownership of one AHB slave among MASTER_NUM masters. A master
// keeps the slave for a whole burst; ownership is re-arbitrated when the
// owner finishes (hlast with hwait low) or withdraws its request. The
// arbitration result is computed combinationally and registered, so a grant
// appears one cycle after the request or release that caused it.
// Arbitration modes: 0 fixed priority (lowest index), 1 dynamic priority
// (highest hprior, ties to lowest index), 2 round robin. With STARVE_LIMIT > 0
// a master that has waited STARVE_LIMIT cycles overrides the mode.
// Ports:
//   hclk     : clock, rising edge
//   hreset_n : asynchronous active-low reset
//   bus      : ahb_arbiter_slave_gen_if slave modport (hreq, hlast, hprior,
//              hwait in; hgrant, hsel, hmaster out)
module ahb_arbiter_slave_gen #(
  parameter int MASTER_NUM   = 4,
  parameter int PRIOR_LEVEL  = 4,
  parameter int PRIOR_BIT    = $clog2(PRIOR_LEVEL),
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 15
) (
  input logic                    hclk,
  input logic                    hreset_n,
  ahb_arbiter_slave_gen_if.slave bus
);
  localparam int MW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t                  state;
  logic [MASTER_NUM-1:0]   grant_reg;
  logic [MW-1:0]           rr_ptr;
  logic [MW-1:0]           owner;
  logic                    release_now;
  logic                    arb_load;
  logic [MASTER_NUM-1:0]   starved;
  logic                    win_valid;
  logic [MW-1:0]           win_idx;
  logic [MASTER_NUM-1:0]   win_onehot;
  logic                    found;
  logic [PRIOR_BIT-1:0]    best_prio;
  int                      rr_idx;

  function automatic logic [MW-1:0] encode(input logic [MASTER_NUM-1:0] v);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (v[i]) r = MW'(i);
    end
    return r;
  endfunction

  assign owner = encode(grant_reg);

  // Masking with grant_reg picks out the owner's bits without an index that
  // could fall outside the vector for non-power-of-two MASTER_NUM.
  assign release_now = (state == OWN) &&
                       (((|(bus.hlast & grant_reg)) && !bus.hwait) ||
                        !(|(bus.hreq & grant_reg)));

  assign arb_load = (state == IDLE) || release_now;

  // Winner selection. Starved masters beat everything; otherwise the mode
  // decides. The releasing owner still competes at its normal rank.
  always_comb begin
    win_valid = |bus.hreq;
    win_idx   = '0;
    found     = 1'b0;
    best_prio = '0;
    rr_idx    = 0;
    if (|starved) begin
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
        if (starved[i]) win_idx = MW'(i);
      end
    end else if (ARB_MODE == 2) begin
      for (int k = 1; k <= MASTER_NUM; k++) begin
        rr_idx = int'(rr_ptr) + k;
        if (rr_idx >= MASTER_NUM) rr_idx = rr_idx - MASTER_NUM;
        if (!found && bus.hreq[rr_idx]) begin
          win_idx = MW'(rr_idx);
          found   = 1'b1;
        end
      end
    end else if (ARB_MODE == 1) begin
      // Strict greater-than keeps the lowest index on ties.
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (bus.hreq[i] &&
            (!found || (bus.hprior[i*PRIOR_BIT +: PRIOR_BIT] > best_prio))) begin
          best_prio = bus.hprior[i*PRIOR_BIT +: PRIOR_BIT];
          win_idx   = MW'(i);
          found     = 1'b1;
        end
      end
    end else begin
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
        if (bus.hreq[i]) win_idx = MW'(i);
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      win_onehot[i] = (win_idx == MW'(i));
    end
  end

  // Ownership FSM. Grant and round-robin pointer only move when the slave is
  // free or the owner releases; a release with requests pending hands over
  // directly without passing through IDLE.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= IDLE;
      grant_reg <= '0;
      rr_ptr    <= MW'(MASTER_NUM - 1);
    end else if (arb_load) begin
      if (win_valid) begin
        state     <= OWN;
        grant_reg <= win_onehot;
        rr_ptr    <= win_idx;
      end else begin
        state     <= IDLE;
        grant_reg <= '0;
      end
    end
  end

  generate
    if (STARVE_LIMIT > 0) begin : g_age
      localparam int CW = $clog2(STARVE_LIMIT + 1);
      logic [CW-1:0] wait_cnt [MASTER_NUM];

      // A counter restarts whenever its master is not waiting: not requesting,
      // currently owning, or winning on this edge.
      always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
          for (int i = 0; i < MASTER_NUM; i++) wait_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < MASTER_NUM; i++) begin
            if (!bus.hreq[i] || grant_reg[i] ||
                (arb_load && win_valid && win_onehot[i])) begin
              wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != CW'(STARVE_LIMIT)) begin
              wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
          end
        end
      end

      always_comb begin
        starved = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
          starved[i] = bus.hreq[i] && (wait_cnt[i] == CW'(STARVE_LIMIT));
        end
      end
    end else begin : g_no_age
      assign starved = '0;
    end
  endgenerate

  assign bus.hgrant  = grant_reg & {MASTER_NUM{~bus.hwait}};
  assign bus.hsel    = |grant_reg;
  assign bus.hmaster = owner;

  a_grant_onehot0: assert property (@(posedge hclk) $onehot0(grant_reg));

endmodule

// File: tb/tb_ahb_arbiter_slave_gen.sv
// tb_ahb_arbiter_slave_gen
// Directed checks of ahb_arbiter_slave_gen in several configurations sharing
// one clock and reset:
//   dut_a : fixed priority, no aging
//   dut_b : dynamic priority, default aging
//   dut_c : round robin
//   dut_d : fixed priority, STARVE_LIMIT = 3
//   dut_e : single master
module tb_ahb_arbiter_slave_gen;
  logic hclk;
  logic hreset_n;
  int   checks;
  int   failures;

  ahb_arbiter_slave_gen_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) if_a ();
  ahb_arbiter_slave_gen_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) if_b ();
  ahb_arbiter_slave_gen_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) if_c ();
  ahb_arbiter_slave_gen_if #(.MASTER_NUM(4), .PRIOR_BIT(2)) if_d ();
  ahb_arbiter_slave_gen_if #(.MASTER_NUM(1), .PRIOR_BIT(2)) if_e ();

  ahb_arbiter_slave_gen #(.MASTER_NUM(4), .ARB_MODE(0), .STARVE_LIMIT(0)) dut_a (
    .hclk(hclk), .hreset_n(hreset_n), .bus(if_a));
  ahb_arbiter_slave_gen #(.MASTER_NUM(4), .ARB_MODE(1)) dut_b (
    .hclk(hclk), .hreset_n(hreset_n), .bus(if_b));
  ahb_arbiter_slave_gen #(.MASTER_NUM(4), .ARB_MODE(2)) dut_c (
    .hclk(hclk), .hreset_n(hreset_n), .bus(if_c));
  ahb_arbiter_slave_gen #(.MASTER_NUM(4), .ARB_MODE(0), .STARVE_LIMIT(3)) dut_d (
    .hclk(hclk), .hreset_n(hreset_n), .bus(if_d));
  ahb_arbiter_slave_gen #(.MASTER_NUM(1)) dut_e (
    .hclk(hclk), .hreset_n(hreset_n), .bus(if_e));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int rr_seq [8];
    int age_seq [9];
    rr_seq  = '{0, 1, 2, 3, 0, 1, 2, 3};
    age_seq = '{0, 0, 0, 2, 0, 0, 0, 0, 2};
    checks   = 0;
    failures = 0;

    hreset_n = 1'b0;
    if_a.hreq = '0; if_a.hlast = '0; if_a.hprior = '0; if_a.hwait = 1'b0;
    if_b.hreq = '0; if_b.hlast = '0; if_b.hprior = '0; if_b.hwait = 1'b0;
    if_c.hreq = '0; if_c.hlast = '0; if_c.hprior = '0; if_c.hwait = 1'b0;
    if_d.hreq = '0; if_d.hlast = '0; if_d.hprior = '0; if_d.hwait = 1'b0;
    if_e.hreq = '0; if_e.hlast = '0; if_e.hprior = '0; if_e.hwait = 1'b0;

    #12;
    checkOutput("reset_hgrant", 32'(if_a.hgrant), 32'h0);
    checkOutput("reset_hsel", 32'(if_a.hsel), 32'h0);
    checkOutput("reset_hmaster", 32'(if_a.hmaster), 32'h0);
    hreset_n = 1'b1;
    applyStimulus(1);
    checkOutput("idle_no_req_hsel", 32'(if_a.hsel), 32'h0);

    $display("[TB] fixed priority handover");
    if_a.hreq = 4'b1010;
    applyStimulus(1);
    checkOutput("m0_first_hgrant", 32'(if_a.hgrant), 32'h2);
    checkOutput("m0_first_hmaster", 32'(if_a.hmaster), 32'h1);
    checkOutput("m0_first_hsel", 32'(if_a.hsel), 32'h1);
    applyStimulus(2);
    checkOutput("m0_hold_hgrant", 32'(if_a.hgrant), 32'h2);
    if_a.hlast = 4'b0010;
    if_a.hreq  = 4'b1000;
    applyStimulus(1);
    checkOutput("m0_handover_hgrant", 32'(if_a.hgrant), 32'h8);
    checkOutput("m0_handover_hmaster", 32'(if_a.hmaster), 32'h3);
    checkOutput("m0_handover_hsel", 32'(if_a.hsel), 32'h1);
    if_a.hlast = '0;
    if_a.hreq  = '0;
    applyStimulus(1);
    checkOutput("m0_idle_hsel", 32'(if_a.hsel), 32'h0);
    checkOutput("m0_idle_hmaster", 32'(if_a.hmaster), 32'h0);
    checkOutput("m0_idle_hgrant", 32'(if_a.hgrant), 32'h0);

    $display("[TB] abort by dropping hreq");
    if_a.hreq = 4'b0100;
    applyStimulus(1);
    checkOutput("abort_own2", 32'(if_a.hmaster), 32'h2);
    if_a.hreq = 4'b0101;
    applyStimulus(2);
    checkOutput("abort_hold2", 32'(if_a.hmaster), 32'h2);
    if_a.hreq = 4'b0001;
    applyStimulus(1);
    checkOutput("abort_to0_hgrant", 32'(if_a.hgrant), 32'h1);
    checkOutput("abort_to0_hsel", 32'(if_a.hsel), 32'h1);

    $display("[TB] reset mid-burst");
    #3;
    hreset_n = 1'b0;
    #1;
    checkOutput("rst_mid_hgrant", 32'(if_a.hgrant), 32'h0);
    checkOutput("rst_mid_hsel", 32'(if_a.hsel), 32'h0);
    checkOutput("rst_mid_hmaster", 32'(if_a.hmaster), 32'h0);
    applyStimulus(1);
    checkOutput("rst_held_hsel", 32'(if_a.hsel), 32'h0);
    #2;
    hreset_n = 1'b1;
    #1;
    checkOutput("rst_rel_hsel", 32'(if_a.hsel), 32'h0);
    applyStimulus(1);
    checkOutput("rst_after_hgrant", 32'(if_a.hgrant), 32'h1);
    if_a.hreq = '0;

    $display("[TB] dynamic priority with wait states");
    if_b.hprior = {2'd1, 2'd3, 2'd3, 2'd0};
    if_b.hreq   = 4'b1111;
    applyStimulus(1);
    checkOutput("m1_tie_hgrant", 32'(if_b.hgrant), 32'h2);
    if_b.hlast = 4'b0010;
    if_b.hwait = 1'b1;
    #1;
    checkOutput("m1_wait_hgrant", 32'(if_b.hgrant), 32'h0);
    checkOutput("m1_wait_hsel", 32'(if_b.hsel), 32'h1);
    applyStimulus(1);
    checkOutput("m1_wait_hold_hgrant", 32'(if_b.hgrant), 32'h0);
    checkOutput("m1_wait_hold_hmaster", 32'(if_b.hmaster), 32'h1);
    applyStimulus(1);
    checkOutput("m1_wait_hold2_hmaster", 32'(if_b.hmaster), 32'h1);
    if_b.hwait = 1'b0;
    if_b.hreq  = 4'b1101;
    #1;
    checkOutput("m1_unwait_hgrant", 32'(if_b.hgrant), 32'h2);
    applyStimulus(1);
    checkOutput("m1_next_prio_hgrant", 32'(if_b.hgrant), 32'h4);
    if_b.hlast = 4'b0100;
    if_b.hreq  = 4'b1001;
    applyStimulus(1);
    checkOutput("m1_prio1_hmaster", 32'(if_b.hmaster), 32'h3);
    if_b.hlast = '0;
    if_b.hreq  = '0;
    applyStimulus(1);
    checkOutput("m1_idle_hsel", 32'(if_b.hsel), 32'h0);

    $display("[TB] round robin rotation");
    if_c.hreq  = 4'b1111;
    if_c.hlast = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("rr_step%0d_hmaster", k), 32'(if_c.hmaster),
                  32'(rr_seq[k]));
      checkOutput($sformatf("rr_step%0d_hgrant", k), 32'(if_c.hgrant),
                  32'(1) << rr_seq[k]);
    end
    if_c.hreq  = '0;
    if_c.hlast = '0;

    $display("[TB] aging under fixed priority");
    if_d.hreq  = 4'b0101;
    if_d.hlast = 4'b0101;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("age_step%0d_hmaster", k), 32'(if_d.hmaster),
                  32'(age_seq[k]));
    end
    if_d.hreq  = '0;
    if_d.hlast = '0;

    $display("[TB] single master");
    if_e.hreq = 1'b1;
    applyStimulus(1);
    checkOutput("n1_grant", 32'(if_e.hgrant), 32'h1);
    checkOutput("n1_hmaster", 32'(if_e.hmaster), 32'h0);
    if_e.hlast = 1'b1;
    applyStimulus(1);
    checkOutput("n1_regrant", 32'(if_e.hgrant), 32'h1);
    if_e.hreq  = 1'b0;
    if_e.hlast = 1'b0;
    applyStimulus(1);
    checkOutput("n1_idle_hsel", 32'(if_e.hsel), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
